instr_mem_loader: RTL and testbench

Byte-stream loader that writes a program image into the instruction memory read by the multi-cycle CPU core. It holds the CPU in reset and accepts a framed byte stream over a valid/ready handshake. The frame is a 16-bit word count, big-endian instruction words and an 8-bit checksum. The block assembles the bytes into 32-bit words, writes them at consecutive byte addresses 0, 4, 8, …, and releases the CPU only after a frame with a correct checksum.

---
 rtl/instr_mem_loader.sv | 137 +++++++++++++
 tb/tb_instr_mem_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Loads a framed, checksummed byte stream into instruction memory and holds
// the CPU in reset until a complete, verified program image is present.
//
// state    | meaning
// S_IDLE   | no session yet, CPU held in reset
// S_LEN_HI | waiting for word-count high byte
// S_LEN_LO | waiting for word-count low byte
// S_DATA   | assembling a 32-bit word, MSB first
// S_WRITE  | one-cycle memory write of the assembled word
// S_CHECK  | waiting for the checksum byte
// S_DONE   | image verified, CPU released
// S_ERR    | over-length or bad checksum, CPU held in reset
module instr_mem_loader #(
    parameter int WORDS = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        cpu_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0] WORDS_L = 16'(WORDS);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] shift_q, shift_d;
    logic [15:0] len_full;
    logic        accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
            shift_q    <= shift_d;
        end
    end

    // Outputs depend on the state register only, so in_ready has no path from in_valid.
    assign in_ready_o  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                         (state_q == S_DATA)   || (state_q == S_CHECK);
    assign mem_we_o    = (state_q == S_WRITE);
    assign mem_addr_o  = {14'd0, word_idx_q, 2'b00};
    assign mem_wdata_o = shift_q;
    assign cpu_rst_o   = (state_q != S_DONE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = (state_q == S_ERR);
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);

    assign accept   = in_valid_i && in_ready_o;
    assign len_full = {len_q[15:8], in_data_i};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        shift_d    = shift_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d    = S_LEN_HI;
                    len_d      = '0;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    csum_d     = '0;
                    shift_d    = '0;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data_i;
                    csum_d      = csum_q + in_data_i;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d  = len_full;
                    csum_d = csum_q + in_data_i;
                    if (len_full == 16'd0)
                        state_d = S_CHECK;
                    else if (len_full > WORDS_L)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    shift_d    = {shift_q[23:0], in_data_i};
                    csum_d     = csum_q + in_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                state_d    = (word_idx_q + 16'd1 == len_q) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (accept)
                    state_d = (in_data_i == csum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized frame loads against a frame-level model of the loader: expected
// writes and pass/fail outcome are derived from word count, words and checksum.
module tb_instr_mem_loader;

    localparam int WORDS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] got_q[$];
    logic        we_prev = 1'b0;

    always #5 clk = ~clk;

    instr_mem_loader #(.WORDS(WORDS)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .cpu_rst_o  (cpu_rst),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: record every write, enforce stall and single-cycle strobe.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_q.push_back({mem_addr, mem_wdata});
            check("ready_low_in_write", 64'(in_ready), 64'd0);
            check("we_single_pulse", 64'(we_prev), 64'd0);
        end
        we_prev = mem_we;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ready", 64'(in_ready), 64'd1);
        check("start_busy", 64'(busy), 64'd1);
        check("start_cpu_rst", 64'(cpu_rst), 64'd1);
        check("start_done_clr", 64'({done, err}), 64'd0);
    endtask

    // Offers n bytes starting on a falling edge; a byte counts as taken when
    // valid is offered while in_ready is high across the following rising edge.
    task automatic send(input logic [7:0] bytes[$], input int n, input bit gaps);
        int idx = 0;
        int cyc = 0;
        bit v;
        while (idx < n && cyc < 5000) begin
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid = v;
            in_data  = v ? bytes[idx] : 8'($urandom);
            if (v && in_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (idx < n) check("send_timeout", 64'(idx), 64'(n));
    endtask

    task automatic run_frame(input int len, input logic [31:0] w[$], input bit bad, input bit gaps);
        logic [7:0]  b[$];
        logic [15:0] l16;
        logic [31:0] wd;
        int          sum;
        bit          exp_done;
        l16 = 16'(len);
        b.push_back(l16[15:8]);
        b.push_back(l16[7:0]);
        sum = l16[15:8] + l16[7:0];
        if (len > WORDS) begin
            exp_done = 1'b0;
        end else begin
            for (int i = 0; i < len; i++) begin
                wd = w[i];
                for (int k = 3; k >= 0; k--) begin
                    b.push_back(wd[8*k +: 8]);
                    sum += wd[8*k +: 8];
                end
            end
            b.push_back(8'((sum + (bad ? 1 : 0)) % 256));
            exp_done = !bad;
        end
        got_q.delete();
        pulse_start();
        send(b, b.size(), gaps);
        check("outcome_done", 64'(done), 64'(exp_done));
        check("outcome_err", 64'(err), 64'(!exp_done));
        check("outcome_cpu_rst", 64'(cpu_rst), 64'(!exp_done));
        check("outcome_idle", 64'({busy, in_ready}), 64'd0);
        repeat (3) @(negedge clk);
        if (len > WORDS) begin
            check("write_count", 64'(got_q.size()), 64'd0);
        end else begin
            check("write_count", 64'(got_q.size()), 64'(len));
            for (int i = 0; i < len && i < got_q.size(); i++)
                check("write_entry", got_q[i], {32'(i * 4), w[i]});
        end
    endtask

    logic [31:0] nom[$];
    logic [31:0] none[$];
    logic [31:0] rw[$];
    logic [7:0]  nb[$];

    initial begin
        int len;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_done_err", 64'({done, err}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr_data", {mem_addr, mem_wdata}, 64'd0);
        rst = 1'b0;

        nom = '{32'h20080005, 32'h2009000A};
        run_frame(2, nom, 1'b0, 1'b0);
        run_frame(2, nom, 1'b1, 1'b0);
        run_frame(65, none, 1'b0, 1'b0);
        run_frame(0, none, 1'b0, 1'b1);

        // Reset after six data bytes: only the first word may have landed.
        nb = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09};
        got_q.delete();
        pulse_start();
        send(nb, 8, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_idle", 64'({busy, in_ready, done, err}), 64'd0);
        check("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
        repeat (4) @(negedge clk);
        check("midrst_writes", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) check("midrst_entry", got_q[0], 64'h00000000_20080005);

        // Completed load, then restart from DONE and reload.
        run_frame(2, nom, 1'b0, 1'b0);
        check("restart_pre_done", 64'(done), 64'd1);
        run_frame(2, nom, 1'b0, 1'b1);

        for (int i = 0; i < WORDS; i++) rw.push_back($urandom);
        run_frame(WORDS, rw, 1'b0, 1'b1);

        for (int it = 0; it < 14; it++) begin
            case ($urandom_range(0, 5))
                0:       len = $urandom_range(WORDS + 1, 65535);
                1:       len = 0;
                default: len = $urandom_range(1, 6);
            endcase
            rw.delete();
            for (int i = 0; i < len && i < WORDS; i++) rw.push_back($urandom);
            run_frame(len, rw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
